full_pe: RTL and testbench
==========================

FULL_PE -- requirements
Module: full_pe

Interface
REQ-001 Parameter DATA_W, default 16, signed two's-complement width of input_featuremap, weight and output_featuremap.
REQ-002 Parameter FRAC_W, default 8, number of fractional bits in the shared fixed-point format (Q(DATA_W-FRAC_W).FRAC_W).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 n_reset  input  1  reset, asynchronous, active-high (asserted when 1, despite the codebase port name).
REQ-005 input_featuremap  input  DATA_W signed  activation operand.
REQ-006 weight  input  DATA_W signed  weight operand.
REQ-007 start  input  1  compute enable; a product is captured on each rising edge with start=1.
REQ-008 output_featuremap  output  DATA_W signed  registered scaled product.

Function
REQ-009 Full product P = input_featuremap * weight SHALL be formed at 2*DATA_W bits signed, with no intermediate truncation.
REQ-010 Scaled result SHALL be P arithmetically shifted right by FRAC_W (floor, toward minus infinity) when FULL_PE_ROUND_EN is undefined.
REQ-011 Scaled result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] (-32768..32767 at default) when it exceeds DATA_W bits; no wrap-around.
REQ-012 On a rising edge with start=1 and reset deasserted, output_featuremap SHALL load the saturated scaled result; latency exactly 1 cycle, throughput 1 product per cycle.
REQ-013 On a rising edge with start=0, output_featuremap SHALL hold its previous value.
REQ-014 Operands SHALL be sampled only at the capturing edge; input changes between edges SHALL NOT affect output_featuremap.
REQ-015 The block SHALL contain no state machine and no handshake beyond start; it is a single-stage registered multiplier.
REQ-016 Zero operand SHALL give output 0; (-32768)*(-32768) SHALL saturate to +32767.

Reset
REQ-017 While n_reset=1, output_featuremap SHALL be 0 immediately (asynchronous), independent of clk and start.
REQ-018 Reset asserted mid-operation SHALL discard the pending capture; the first capture after deassertion SHALL occur on the first rising edge with n_reset=0 and start=1.
REQ-019 Reset deassertion coincident with a rising edge SHALL NOT capture on that edge.

Configuration
REQ-020 Macro FULL_PE_ROUND_EN defined: scaled result SHALL be round-half-up, i.e. (P + 2^(FRAC_W-1)) >>> FRAC_W, computed at 2*DATA_W+1 bits before saturation.
REQ-021 Macro FULL_PE_ROUND_EN undefined: truncation per REQ-010; no rounding adder is instantiated.

Verification
REQ-022 n_reset=1 pulse with output previously 0x1234 -> output_featuremap=0 before the next clk edge.
REQ-023 start=1, input=0x0200 (2.0), weight=0x0180 (1.5) -> output_featuremap=0x0300 (3.0) one edge later.
REQ-024 start=1, input=0x7FFF, weight=0x7FFF -> 0x7FFF; input=0x8000, weight=0x7FFF -> 0x8000 (saturation both signs).
REQ-025 start=1, input=0x0001, weight=0x0080 (P=128) -> 0 without FULL_PE_ROUND_EN, 1 with it; input=0xFFFF, weight=0x0001 -> 0xFFFF truncating, 0 rounding.
REQ-026 Capture 0x0300, then start=0 while operands change for 5 cycles -> output stays 0x0300; start=1 again -> new product next edge.
REQ-027 Back-to-back start=1 with 10 random operand pairs -> each output equals reference model of the previous cycle's operands.

Source files
------------

// File: rtl/full_pe.sv
`default_nettype none
// ============================================================================
// Module      : full_pe
// Description : Single-stage registered fixed-point multiplier. It saturates
//               the product to DATA_W bits. Define FULL_PE_ROUND_EN to select
//               round-half-up scaling instead of floor truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module full_pe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic signed [DATA_W-1:0] input_featuremap,
    input  logic signed [DATA_W-1:0] weight,
    input  logic                     start,
    output logic signed [DATA_W-1:0] output_featuremap
);

    localparam int PROD_W = 2 * DATA_W;
`ifdef FULL_PE_ROUND_EN
    localparam int SCL_W = PROD_W + 1;
    localparam logic signed [SCL_W-1:0] c_half = SCL_W'(1) << (FRAC_W - 1);
`else
    localparam int SCL_W = PROD_W;
`endif
    localparam logic signed [DATA_W-1:0] c_max = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_min = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [PROD_W-1:0] w_prod;
    logic signed [SCL_W-1:0]  w_scaled;
    logic        [SCL_W-DATA_W:0] w_hi;
    logic signed [DATA_W-1:0] out_d;
    logic signed [DATA_W-1:0] out_q;

    assign w_prod = $signed({{DATA_W{input_featuremap[DATA_W-1]}}, input_featuremap})
                  * $signed({{DATA_W{weight[DATA_W-1]}}, weight});

`ifdef FULL_PE_ROUND_EN
    // One extra bit so the rounding bias can never overflow the product.
    logic signed [SCL_W-1:0] w_biased;
    assign w_biased = $signed({w_prod[PROD_W-1], w_prod}) + c_half;
    assign w_scaled = w_biased >>> FRAC_W;
`else
    assign w_scaled = w_prod >>> FRAC_W;
`endif

    // The result fits in DATA_W bits only when all bits above the sign bit match it.
    assign w_hi = w_scaled[SCL_W-1:DATA_W-1];

    always_comb begin
        out_d = w_scaled[DATA_W-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            out_d = w_scaled[SCL_W-1] ? c_min : c_max;
        end
    end

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            out_q <= '0;
        end else if (start) begin
            out_q <= out_d;
        end
    end

    assign output_featuremap = out_q;

endmodule
`default_nettype wire

// File: tb/tb_full_pe.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_pe
// Description : Self-checking bench for full_pe. It applies directed vectors
//               and hand sequences, then random back-to-back captures.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_pe;

    localparam int DW = 16;
    localparam int FW = 8;

    logic                 clk = 1'b0;
    logic                 n_reset;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic                 st;
    logic signed [DW-1:0] y;

    int checks   = 0;
    int failures = 0;

    full_pe #(.DATA_W(DW), .FRAC_W(FW)) dut (
        .clk               (clk),
        .n_reset           (n_reset),
        .input_featuremap  (a),
        .weight            (b),
        .start             (st),
        .output_featuremap (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          st;
        logic [DW-1:0] exp_trunc;
        logic [DW-1:0] exp_round;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] w);
        longint p;
        p = longint'($signed(x)) * longint'($signed(w));
`ifdef FULL_PE_ROUND_EN
        p = p + 128;
`endif
        p = p >>> FW;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[DW-1:0];
    endfunction

    task automatic step(input logic [DW-1:0] x, input logic [DW-1:0] w, input logic s);
        a  = x;
        b  = w;
        st = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_v;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;

        vecs[0]  = '{16'h0200, 16'h0180, 1'b1, 16'h0300, 16'h0300};
        vecs[1]  = '{16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 16'h7FFF};
        vecs[2]  = '{16'h8000, 16'h7FFF, 1'b1, 16'h8000, 16'h8000};
        vecs[3]  = '{16'h8000, 16'h8000, 1'b1, 16'h7FFF, 16'h7FFF};
        vecs[4]  = '{16'h0001, 16'h0080, 1'b1, 16'h0000, 16'h0001};
        vecs[5]  = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'h0000};
        vecs[6]  = '{16'h0000, 16'h1234, 1'b1, 16'h0000, 16'h0000};
        vecs[7]  = '{16'h5A5A, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[8]  = '{16'hFF00, 16'h0200, 1'b1, 16'hFE00, 16'hFE00};
        vecs[9]  = '{16'h0180, 16'h0180, 1'b1, 16'h0240, 16'h0240};
        vecs[10] = '{16'h7FFF, 16'h0100, 1'b1, 16'h7FFF, 16'h7FFF};
        vecs[11] = '{16'h8000, 16'h0100, 1'b1, 16'h8000, 16'h8000};
        vecs[12] = '{16'h0081, 16'h0001, 1'b1, 16'h0000, 16'h0001};
        vecs[13] = '{16'hFF7F, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF};

        n_reset = 1'b1;
        a  = '0;
        b  = '0;
        st = 1'b1;
        #2;
        check("reset_async", y, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_held_start1", y, 16'h0000);
        n_reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].st);
`ifdef FULL_PE_ROUND_EN
            check($sformatf("vec%0d", i), y, vecs[i].exp_round);
`else
            check($sformatf("vec%0d", i), y, vecs[i].exp_trunc);
`endif
        end

        // Capture 0x1234, then pulse reset mid-cycle before the next edge.
        step(16'h1234, 16'h0100, 1'b1);
        check("load_1234", y, 16'h1234);
        a = 16'h0200;
        b = 16'h0180;
        #2;
        n_reset = 1'b1;
        #1;
        check("reset_pulse_clears", y, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_discards_capture", y, 16'h0000);
        n_reset = 1'b0;
        step(16'h0200, 16'h0180, 1'b0);
        check("post_reset_start0", y, 16'h0000);
        step(16'h0200, 16'h0180, 1'b1);
        check("post_reset_first_capture", y, 16'h0300);

        // Hold for five cycles while operands change.
        for (int i = 0; i < 5; i++) begin
            step(16'h0100 + 16'(i * 37), 16'h7000 - 16'(i * 11), 1'b0);
            check($sformatf("hold%0d", i), y, 16'h0300);
        end
        // Operands that glitch between edges must not matter.
        a  = 16'h7FFF;
        b  = 16'h7FFF;
        st = 1'b1;
        #3;
        a = 16'h0180;
        b = 16'h0180;
        @(posedge clk);
        #1;
        check("resume_after_glitch", y, 16'h0240);

        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i < 3) rb = rb >> 6;
            exp_v = model(ra, rb);
            step(ra, rb, 1'b1);
            check($sformatf("rand%0d", i), y, exp_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
